// File: rtl/bus_cycle_sched.sv
// Shares one SRAM port between CPU and DMA, with every access started on a phi1 rising edge. Ack comes WAIT_STATES ticks (+1 clk12) after the grant.
// Requests wait in IDLE until a tick, and only one access is in flight. Define BUS_SCHED_RR_EN for round-robin arbitration; the default is DMA priority.
module bus_cycle_sched #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk12,
  input  logic          reset,
  input  logic          phi1,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_CPU, G_DMA} grant_t;

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          phi1_q;
  logic          tick;
  logic          take;
  logic          pick_dma;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

  assign tick = phi1 & ~phi1_q;

`ifdef BUS_SCHED_RR_EN
  logic rr_q; // 1: DMA wins the next tie
  assign pick_dma = dma_req & (~cpu_req | rr_q);

  always_ff @(posedge clk12) begin
    if (reset)
      rr_q <= 1'b0;
    else if (state_q == S_DONE)
      rr_q <= (grant_q == G_CPU);
  end
`else
  assign pick_dma = dma_req;
`endif

  always_ff @(posedge clk12) begin
    if (reset) begin
      phi1_q  <= 1'b0;
      state_q <= S_IDLE;
      grant_q <= G_NONE;
      wcnt_q  <= 4'd0;
    end else begin
      phi1_q  <= phi1;
      state_q <= state_d;
      grant_q <= grant_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wcnt_d  = wcnt_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick && (cpu_req || dma_req)) begin
          take    = 1'b1;
          grant_d = pick_dma ? G_DMA : G_CPU;
          wcnt_d  = WS;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = (wcnt_q == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (tick) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        grant_d = G_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is valid in the DONE cycle, so it is passed through while ack is high
  always_comb begin
    mem_en    = (state_q == S_ACCESS);
    cpu_ack   = (state_q == S_DONE) && (grant_q == G_CPU);
    dma_ack   = (state_q == S_DONE) && (grant_q == G_DMA);
    cpu_ready = ~(cpu_req & ~cpu_ack);
    cpu_rdata = (cpu_ack & ~mem_we) ? mem_rdata : cpu_rdata_q;
    dma_rdata = (dma_ack & ~mem_we) ? mem_rdata : dma_rdata_q;
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (take) begin
        mem_we    <= pick_dma ? dma_we    : cpu_we;
        mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
        mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
      end
      if (cpu_ack && !mem_we)
        cpu_rdata_q <= mem_rdata;
      if (dma_ack && !mem_we)
        dma_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_bus_cycle_sched.sv
// Directed bench for bus_cycle_sched. It drives two instances, with WAIT_STATES of 0 and 2, and watches one at a time.
// Requests push expected transactions into a queue, and each observed ack pops the queue and checks the result.
module tb_bus_cycle_sched;

  logic        clk12 = 1'b0;
  logic        reset, phi1;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        watch;

  logic        u0_cpu_ack, u0_cpu_ready, u0_dma_ack, u0_mem_en, u0_mem_we;
  logic [15:0] u0_cpu_rdata, u0_dma_rdata, u0_mem_addr, u0_mem_wdata;
  logic        u2_cpu_ack, u2_cpu_ready, u2_dma_ack, u2_mem_en, u2_mem_we;
  logic [15:0] u2_cpu_rdata, u2_dma_rdata, u2_mem_addr, u2_mem_wdata;

  logic        w_cpu_ack, w_cpu_ready, w_dma_ack, w_mem_en, w_mem_we;
  logic [15:0] w_cpu_rdata, w_dma_rdata, w_mem_addr, w_mem_wdata;

  always #5 clk12 = ~clk12;

  bus_cycle_sched #(.AW(16), .DW(16), .WAIT_STATES(0)) u0 (
    .clk12(clk12), .reset(reset), .phi1(phi1),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(u0_cpu_ack), .cpu_rdata(u0_cpu_rdata), .cpu_ready(u0_cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(u0_dma_ack), .dma_rdata(u0_dma_rdata),
    .mem_en(u0_mem_en), .mem_we(u0_mem_we), .mem_addr(u0_mem_addr), .mem_wdata(u0_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  bus_cycle_sched #(.AW(16), .DW(16), .WAIT_STATES(2)) u2 (
    .clk12(clk12), .reset(reset), .phi1(phi1),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(u2_cpu_ack), .cpu_rdata(u2_cpu_rdata), .cpu_ready(u2_cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(u2_dma_ack), .dma_rdata(u2_dma_rdata),
    .mem_en(u2_mem_en), .mem_we(u2_mem_we), .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign w_cpu_ack   = watch ? u2_cpu_ack   : u0_cpu_ack;
  assign w_cpu_ready = watch ? u2_cpu_ready : u0_cpu_ready;
  assign w_cpu_rdata = watch ? u2_cpu_rdata : u0_cpu_rdata;
  assign w_dma_ack   = watch ? u2_dma_ack   : u0_dma_ack;
  assign w_dma_rdata = watch ? u2_dma_rdata : u0_dma_rdata;
  assign w_mem_en    = watch ? u2_mem_en    : u0_mem_en;
  assign w_mem_we    = watch ? u2_mem_we    : u0_mem_we;
  assign w_mem_addr  = watch ? u2_mem_addr  : u0_mem_addr;
  assign w_mem_wdata = watch ? u2_mem_wdata : u0_mem_wdata;

  // SRAM stand-in: a read returns addr^5A5A one clock after mem_en, and a write echoes the written data
  always @(posedge clk12) begin
    if (w_mem_en)
      mem_rdata <= w_mem_we ? w_mem_wdata : (w_mem_addr ^ 16'h5A5A);
  end

  typedef struct {
    logic        dma;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc_n = 0, en_cnt = 0, ack_cnt = 0;
  int   last_en_cyc = -1, last_ack_cyc = -1;
  logic ack_ready = 1'b0;
  bit   inflight = 0, auto_drop = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic dma, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    txn_t e;
    e.dma = dma; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = addr ^ 16'h5A5A;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic dma, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    if (dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    push(dma, we, addr, wdata);
  endtask

  // One clk12 cycle: outputs are sampled on the falling edge, and then the scoreboard is updated
  task automatic cyc();
    txn_t e;
    @(posedge clk12);
    cyc_n++;
    @(negedge clk12);
    if (w_mem_en) begin
      en_cnt++;
      last_en_cyc = cyc_n;
      if (exp_q.size() > 0) begin
        chk("mem_we", w_mem_we, exp_q[0].we);
        chk("mem_addr", w_mem_addr, exp_q[0].addr);
        if (exp_q[0].we) chk("mem_wdata", w_mem_wdata, exp_q[0].wdata);
        inflight = 1;
      end
    end else if (inflight && exp_q.size() > 0) begin
      chk("addr_hold", w_mem_addr, exp_q[0].addr);
      if (exp_q[0].we) chk("wdata_hold", w_mem_wdata, exp_q[0].wdata);
    end
    if (w_cpu_ack || w_dma_ack) begin
      chk("ack_onehot", w_cpu_ack & w_dma_ack, 0);
      ack_ready = w_cpu_ready;
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", {w_cpu_ack, w_dma_ack}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_who", w_dma_ack, e.dma);
        if (!e.we) chk("ack_rdata", e.dma ? w_dma_rdata : w_cpu_rdata, e.rdata);
        ack_cnt++;
        last_ack_cyc = cyc_n;
        inflight = 0;
        if (exp_q.size() == 0) begin
          cpu_req = 1'b0; dma_req = 1'b0;
        end else if (auto_drop) begin
          if (e.dma) dma_req = 1'b0; else cpu_req = 1'b0;
        end
      end
    end
  endtask

  task automatic tick_pulse(input int hi, input int lo, output int t_edge);
    phi1 = 1'b1;
    t_edge = cyc_n + 1;
    repeat (hi) cyc();
    phi1 = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; phi1 = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    exp_q.delete();
    inflight = 0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    int t, g, u1, u2, b, x, e0, a0;
    reset = 1'b1; phi1 = 1'b0; watch = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;

    // Values while reset is held
    repeat (2) cyc();
    chk("rst_cpu_ack", w_cpu_ack, 0);
    chk("rst_dma_ack", w_dma_ack, 0);
    chk("rst_mem_en", w_mem_en, 0);
    chk("rst_mem_we", w_mem_we, 0);
    chk("rst_mem_addr", w_mem_addr, 0);
    chk("rst_mem_wdata", w_mem_wdata, 0);
    chk("rst_cpu_rdata", w_cpu_rdata, 0);
    chk("rst_dma_rdata", w_dma_rdata, 0);
    chk("rst_cpu_ready", w_cpu_ready, 1);

    // CPU read, then a CPU write, with zero wait states
    watch = 1'b0;
    do_reset();
    issue(1'b0, 1'b0, 16'hFF00, 16'h0000);
    cyc();
    chk("t1_ready_wait", w_cpu_ready, 0);
    chk("t1_no_en_before_tick", w_mem_en, 0);
    phi1 = 1'b1; t = cyc_n + 1;
    cyc();
    chk("t1_en_cycle", last_en_cyc, t);
    chk("t1_ready_in_access", w_cpu_ready, 0);
    cyc();
    chk("t1_ack_cycle", last_ack_cyc, t + 1);
    chk("t1_ready_at_ack", ack_ready, 1);
    phi1 = 1'b0;
    cyc();
    chk("t1_ack_single", w_cpu_ack, 0);
    chk("t1_rdata_held", w_cpu_rdata, 16'hA55A);
    issue(1'b0, 1'b1, 16'h0F0F, 16'hBEEF);
    phi1 = 1'b1; t = cyc_n + 1;
    cyc(); cyc();
    phi1 = 1'b0;
    cyc();
    chk("t1_wr_ack_cycle", last_ack_cyc, t + 1);
    chk("t1_rdata_not_from_write", w_cpu_rdata, 16'hA55A);

    // CPU write with two wait states
    watch = 1'b1;
    do_reset();
    e0 = en_cnt; a0 = ack_cnt;
    issue(1'b0, 1'b1, 16'h8300, 16'h1234);
    tick_pulse(2, 2, g);
    chk("t2_en_at_grant", last_en_cyc, g);
    tick_pulse(2, 2, u1);
    chk("t2_no_early_ack", ack_cnt, a0);
    tick_pulse(2, 2, u2);
    chk("t2_ack_after_2nd_tick", last_ack_cyc, u2);
    chk("t2_one_en", en_cnt - e0, 1);
    chk("t2_one_ack", ack_cnt - a0, 1);

    // Reset during WAIT with one tick left
    do_reset();
    issue(1'b0, 1'b1, 16'h1111, 16'h7777);
    tick_pulse(2, 2, g);
    tick_pulse(2, 2, u1);
    reset = 1'b1; cpu_req = 1'b0;
    exp_q.delete();
    inflight = 0;
    a0 = ack_cnt;
    cyc();
    chk("t5_mem_en", w_mem_en, 0);
    chk("t5_mem_we", w_mem_we, 0);
    chk("t5_mem_addr", w_mem_addr, 0);
    chk("t5_mem_wdata", w_mem_wdata, 0);
    chk("t5_cpu_ack", w_cpu_ack, 0);
    reset = 1'b0;
    e0 = en_cnt;
    tick_pulse(2, 2, x);
    tick_pulse(2, 2, x);
    chk("t5_no_ack_after_abort", ack_cnt, a0);
    chk("t5_no_restart", en_cnt, e0);
    issue(1'b0, 1'b0, 16'h2222, 16'h0000);
    tick_pulse(2, 2, g);
    tick_pulse(2, 2, u1);
    tick_pulse(2, 2, u2);
    chk("t5_new_access_acked", ack_cnt, a0 + 1);
    chk("t5_new_ack_cycle", last_ack_cyc, u2);
    chk("t5_rdata_held", w_cpu_rdata, 16'h7878);

    // Request raised while phi1 is already high, so the next rising edge starts the access
    watch = 1'b0;
    do_reset();
    phi1 = 1'b1;
    cyc();
    e0 = en_cnt; a0 = ack_cnt;
    issue(1'b0, 1'b0, 16'h3333, 16'h0000);
    cyc(); cyc();
    chk("t6_level_ignored", en_cnt, e0);
    phi1 = 1'b0;
    cyc(); cyc();
    chk("t6_wait_for_edge", en_cnt, e0);
    tick_pulse(2, 2, b);
    chk("t6_en_at_edge", last_en_cyc, b);
    chk("t6_ack_cycle", last_ack_cyc, b + 1);
    tick_pulse(2, 2, x);
    chk("t6_one_access", en_cnt - e0, 1);
    chk("t6_one_ack", ack_cnt - a0, 1);

`ifdef BUS_SCHED_RR_EN
    // Both requesters held high for four accesses, so grants alternate starting with CPU
    do_reset();
    auto_drop = 0;
    a0 = ack_cnt;
    issue(1'b0, 1'b0, 16'h0101, 16'h0000);
    issue(1'b1, 1'b0, 16'h0202, 16'h0000);
    push(1'b0, 1'b0, 16'h0101, 16'h0000);
    push(1'b1, 1'b0, 16'h0202, 16'h0000);
    for (int i = 0; i < 4; i++) tick_pulse(2, 2, x);
    tick_pulse(2, 2, x);
    chk("t4_four_acks", ack_cnt - a0, 4);
    chk("t4_queue_drained", exp_q.size(), 0);
    auto_drop = 1;
`else
    // Simultaneous requests: DMA is served first, then CPU at the next tick
    do_reset();
    a0 = ack_cnt;
    issue(1'b1, 1'b0, 16'h5555, 16'h0000);
    issue(1'b0, 1'b1, 16'h4444, 16'h0BAD);
    tick_pulse(2, 2, g);
    chk("t3_dma_done", ack_cnt - a0, 1);
    chk("t3_dma_ack_cycle", last_ack_cyc, g + 1);
    tick_pulse(2, 2, u1);
    chk("t3_cpu_grant_next_tick", last_en_cyc, u1);
    chk("t3_two_acks", ack_cnt - a0, 2);
    chk("t3_dma_rdata_held", w_dma_rdata, 16'h0F0F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed %0d cycles", cyc_n);
    $fatal(1, "watchdog expired");
  end

endmodule
